// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH / DECODE / EXEC / HALTED over one req/ack memory port.
// Latency: memory-operand instr 3 cycles, BNE/JMP/NOP 2 cycles, each wait state adds 1 cycle.
// Backpressure: mem_req and its address/we/data hold steady until mem_ack; ack without req ignored.
// Optional feature: define IO_PORT_EN to map address 2^ADDR_W-1 onto io_in/io_out for data accesses.
module acc_cpu_core #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3,
   parameter int ADDR_W = WORD_W - OP_W
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [WORD_W-1:0] acc_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              z_flag,
   output logic              halted,
   input  logic [WORD_W-1:0] io_in,
   output logic [WORD_W-1:0] io_out
);

   // Instruction word: opcode in the top bits, address field below it.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   instr_t            ir_q, ir_d;

   logic              req_c;
   logic              we_c;
   logic [ADDR_W-1:0] addr_c;
   logic              exec_io;
   logic [WORD_W-1:0] operand;

`ifdef IO_PORT_EN
   localparam logic [ADDR_W-1:0] IO_ADDR = '1;

   logic [WORD_W-1:0] io_q, io_d;

   // Data accesses to the top address hit the internal port; fetches never look at this.
   assign exec_io = (ir_q.addr == IO_ADDR);
   assign operand = exec_io ? io_in : mem_rdata;
   assign io_out  = io_q;

   // Output latch for STORE to the I/O address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_q <= '0;
      end else begin
         io_q <= io_d;
      end
   end
`else
   logic unused_io_in;

   assign unused_io_in = ^io_in;
   assign exec_io      = 1'b0;
   assign operand      = mem_rdata;
   assign io_out       = '0;
`endif

   // State and architectural registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         acc_q   <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state, datapath updates and memory request decode (request never depends on ack).
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      ir_d    = ir_q;
      req_c   = 1'b0;
      we_c    = 1'b0;
      addr_c  = pc_q;
`ifdef IO_PORT_EN
      io_d    = io_q;
`endif
      case (state_q)
         S_FETCH: begin
            req_c  = 1'b1;
            addr_c = pc_q;
            if (mem_ack) begin
               ir_d    = instr_t'(mem_rdata);
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (ir_q.op)
               OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: state_d = S_EXEC;
               OP_BNE: begin
                  if (acc_q != '0) begin
                     pc_d = ir_q.addr;
                  end
                  state_d = S_FETCH;
               end
               OP_JMP: begin
                  pc_d    = ir_q.addr;
                  state_d = S_FETCH;
               end
               OP_HALT: state_d = S_HALTED;
               default: state_d = S_FETCH;
            endcase
         end
         S_EXEC: begin
            addr_c = ir_q.addr;
            req_c  = ~exec_io;
            we_c   = ~exec_io & (ir_q.op == OP_STORE);
            // Internal I/O completes immediately; external access waits for ack.
            if (exec_io || mem_ack) begin
               case (ir_q.op)
                  OP_LOAD: acc_d = operand;
                  OP_ADD:  acc_d = acc_q + operand;
                  OP_SUB:  acc_d = acc_q - operand;
                  OP_XOR:  acc_d = acc_q ^ operand;
                  default: acc_d = acc_q;
               endcase
`ifdef IO_PORT_EN
               if (exec_io && (ir_q.op == OP_STORE)) begin
                  io_d = acc_q;
               end
`endif
               state_d = S_FETCH;
            end
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_FETCH;
      endcase
   end

   // Reset gates the request so an outstanding transaction is dropped immediately.
   assign mem_req   = req_c & ~reset;
   assign mem_we    = we_c & ~reset;
   assign mem_addr  = addr_c;
   assign mem_wdata = acc_q;

   assign acc_out = acc_q;
   assign pc_out  = pc_q;
   assign z_flag  = (acc_q == '0);
   assign halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus random programs against an ISA-level model.
// Latency: checks cycle counts from reset release to halted against the model.
// Backpressure: memory responder inserts configurable wait states and random acks while idle.
module tb_acc_cpu_core;
   localparam int WORD_W = 8;
   localparam int OP_W   = 3;
   localparam int ADDR_W = 5;
   localparam int NMEM   = 32;

   typedef struct packed {
      logic       we;
      logic [4:0] addr;
      logic [7:0] data;
   } txn_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic [WORD_W-1:0] acc_out;
   logic [ADDR_W-1:0] pc_out;
   logic              z_flag, halted;
   logic [WORD_W-1:0] io_in = 8'h5A;
   logic [WORD_W-1:0] io_out;

   acc_cpu_core #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
      .clock(clock), .reset(reset),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .acc_out(acc_out), .pc_out(pc_out), .z_flag(z_flag), .halted(halted),
      .io_in(io_in), .io_out(io_out)
   );

   always #5 clock = ~clock;

   logic [7:0] mem     [NMEM];
   logic [7:0] ref_mem [NMEM];
   txn_t       txq[$];
   txn_t       ex_q[$];
   int         wait_cfg = 0;
   int         wcnt = 0;
   bit         pend = 0;
   logic       p_we;
   logic [4:0] p_addr;
   logic [7:0] p_wdata;
   logic [7:0] exp_acc;
   logic [4:0] exp_pc;
   int         exp_cyc;
   int         pc_tr [64];
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] ins(input int op, input int a);
      return {3'(op), 5'(a)};
   endfunction

   // Memory responder: drives ack/rdata on the falling edge, checks request stability while waiting.
   always @(negedge clock) begin
      if (reset) begin
         wcnt = 0; pend = 0; mem_ack = 1'b0;
      end else if (mem_req) begin
         if (pend) begin
            chk("hold_addr", 32'(mem_addr), 32'(p_addr));
            chk("hold_we", 32'(mem_we), 32'(p_we));
            if (p_we) chk("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
         end
         mem_rdata = mem[mem_addr];
         if (wcnt >= wait_cfg) begin
            mem_ack = 1'b1;
            txq.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : mem[mem_addr])});
            if (mem_we) mem[mem_addr] = mem_wdata;
            wcnt = 0; pend = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++; pend = 1;
            p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
         end
      end else begin
         mem_ack   = 1'($urandom);
         mem_rdata = 8'($urandom);
         wcnt = 0; pend = 0;
      end
   end

   // ISA-level reference: interprets the program instruction by instruction.
   task automatic model(input int wt);
      int pc = 0;
      logic [7:0] acc = 8'h00;
      logic [7:0] iw, d;
      int op, a;
      ex_q.delete();
      exp_cyc = 0;
      for (int step = 0; step < 200; step++) begin
         iw = ref_mem[pc];
         ex_q.push_back('{we: 1'b0, addr: 5'(pc), data: iw});
         exp_cyc += 2 + wt;
         pc = (pc + 1) % NMEM;
         op = int'(iw[7:5]);
         a  = int'(iw[4:0]);
         if (op == 7) break;
         if (op == 5) begin
            if (acc != 0) pc = a;
         end else if (op == 6) begin
            pc = a;
         end else begin
            exp_cyc += 1 + wt;
            if (op == 1) begin
               ex_q.push_back('{we: 1'b1, addr: 5'(a), data: acc});
               ref_mem[a] = acc;
            end else begin
               d = ref_mem[a];
               ex_q.push_back('{we: 1'b0, addr: 5'(a), data: d});
               if (op == 0) acc = d;
               else if (op == 2) acc = acc + d;
               else if (op == 3) acc = acc - d;
               else acc = acc ^ d;
            end
         end
      end
      exp_acc = acc;
      exp_pc  = 5'(pc);
   endtask

   task automatic run_prog(input int wt, input int limit, output int cycles);
      reset = 1'b1;
      wait_cfg = wt;
      @(negedge clock);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_acc", 32'(acc_out), 0);
      chk("rst_pc", 32'(pc_out), 0);
      chk("rst_z", 32'(z_flag), 1);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_io_out", 32'(io_out), 0);
      txq.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      cycles = 0;
      while (cycles < limit) begin
         @(posedge clock); #1;
         cycles++;
         if (cycles < 64) pc_tr[cycles] = int'(pc_out);
         if (halted) break;
      end
      if (!halted) chk("halt_timeout", 0, 1);
      repeat (4) begin
         @(negedge clock);
         chk("req_after_halt", 32'(mem_req), 0);
      end
   endtask

   task automatic compare_run(input string p, input int cyc);
      chk({p, "_ntxn"}, 32'(txq.size()), 32'(ex_q.size()));
      for (int i = 0; i < ex_q.size() && i < txq.size(); i++)
         chk({p, "_txn"}, 32'(txq[i]), 32'(ex_q[i]));
      chk({p, "_acc"}, 32'(acc_out), 32'(exp_acc));
      chk({p, "_z"}, 32'(z_flag), 32'(exp_acc == 8'h00));
      chk({p, "_pc"}, 32'(pc_out), 32'(exp_pc));
      chk({p, "_halted"}, 32'(halted), 1);
      chk({p, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      for (int a = 0; a < NMEM; a++) chk({p, "_mem"}, 32'(mem[a]), 32'(ref_mem[a]));
   endtask

   task automatic clear_mem();
      for (int a = 0; a < NMEM; a++) mem[a] = 8'h00;
   endtask

   task automatic gen_prog();
      for (int a = 0; a < NMEM; a++) mem[a] = 8'($urandom);
      for (int a = 0; a < 15; a++) begin
         int op;
         int t;
         op = int'($urandom_range(0, 6));
         if (op >= 5) t = int'($urandom_range(a + 1, 15));
         else t = int'($urandom_range(16, 30));
         mem[a] = ins(op, t);
      end
      mem[15] = ins(7, 0);
   endtask

   initial begin
      int cyc;
      bit found;

      // Basic program, zero wait and three wait states.
      for (int w = 0; w <= 3; w += 3) begin
         clear_mem();
         mem[0] = ins(0, 10); mem[1] = ins(2, 11); mem[2] = ins(1, 12); mem[3] = ins(7, 0);
         mem[10] = 8'd3; mem[11] = 8'd4;
         ref_mem = mem;
         model(w);
         run_prog(w, 500, cyc);
         compare_run(w == 0 ? "prog_w0" : "prog_w3", cyc);
         chk("prog_m12", 32'(mem[12]), 7);
         chk("prog_acc", 32'(acc_out), 7);
         chk("prog_cycles", 32'(cyc), 32'(11 + 7 * w));
      end

      // Wrap to zero: FF + 1.
      clear_mem();
      mem[0] = ins(0, 10); mem[1] = ins(2, 11); mem[2] = ins(7, 0);
      mem[10] = 8'hFF; mem[11] = 8'h01;
      run_prog(0, 500, cyc);
      chk("wrap_add_acc", 32'(acc_out), 0);
      chk("wrap_add_z", 32'(z_flag), 1);

      // Wrap below zero: 0 - 1.
      clear_mem();
      mem[0] = ins(3, 11); mem[1] = ins(7, 0); mem[11] = 8'h01;
      run_prog(0, 500, cyc);
      chk("wrap_sub_acc", 32'(acc_out), 32'h0FF);
      chk("wrap_sub_z", 32'(z_flag), 0);

      // BNE not taken with ACC=0, taken after LOAD 5.
      clear_mem();
      mem[0] = ins(5, 20); mem[1] = ins(0, 16); mem[2] = ins(5, 20); mem[20] = ins(7, 0);
      mem[16] = 8'd5;
      run_prog(1, 500, cyc);
      chk("bne_ntxn", 32'(txq.size()), 5);
      if (txq.size() == 5) begin
         chk("bne_nt_fetch", 32'(txq[1].addr), 1);
         chk("bne_ld_addr", 32'(txq[2].addr), 16);
         chk("bne_tk_fetch", 32'(txq[4].addr), 20);
      end

      // JMP to the top address, fetch there wraps PC to 0.
      clear_mem();
      mem[0] = ins(6, 31); mem[31] = ins(6, 2); mem[2] = ins(7, 0);
      run_prog(0, 500, cyc);
      chk("jmp_top_fetch", 32'(txq.size() > 1 ? txq[1].addr : 5'd0), 31);
      chk("jmp_pc_wrap", 32'(pc_tr[3]), 0);
      chk("jmp_pc_tgt", 32'(pc_tr[4]), 2);
      chk("jmp_cycles", 32'(cyc), 6);

      // Reset while EXEC is waiting for ack.
      clear_mem();
      mem[0] = ins(0, 10); mem[1] = ins(2, 11); mem[2] = ins(7, 0);
      mem[10] = 8'd3; mem[11] = 8'd4;
      reset = 1'b1; wait_cfg = 6;
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clock); #1;
         if (mem_req && mem_addr == 5'd11 && !mem_we && acc_out == 8'd3) found = 1;
      end
      chk("mid_rst_reached", 32'(found), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_req", 32'(mem_req), 0);
      chk("mid_rst_pc", 32'(pc_out), 0);
      chk("mid_rst_acc", 32'(acc_out), 0);
      wait_cfg = 0;
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_refetch_req", 32'(mem_req), 1);
      chk("mid_rst_refetch_addr", 32'(mem_addr), 0);

`ifdef IO_PORT_EN
      clear_mem();
      io_in = 8'h5A;
      mem[0] = ins(0, 31); mem[1] = ins(1, 31); mem[2] = ins(7, 0);
      run_prog(0, 500, cyc);
      chk("io_acc", 32'(acc_out), 32'h5A);
      chk("io_out", 32'(io_out), 32'h5A);
      chk("io_ntxn", 32'(txq.size()), 3);
      for (int i = 0; i < txq.size(); i++) chk("io_no_ext", 32'(txq[i].addr), 32'(i));
`else
      clear_mem();
      mem[0] = ins(1, 31); mem[1] = ins(7, 0);
      run_prog(0, 500, cyc);
      chk("st31_ntxn", 32'(txq.size()), 3);
      chk("st31_txn", 32'(txq.size() > 1 ? txq[1] : '0), 32'({1'b1, 5'd31, 8'h00}));
      chk("st31_io_out", 32'(io_out), 0);
`endif

      // Random programs with random wait states.
      for (int r = 0; r < 25; r++) begin
         int wt;
         wt = int'($urandom_range(0, 2));
         io_in = 8'($urandom);
         gen_prog();
         ref_mem = mem;
         model(wt);
         run_prog(wt, 2000, cyc);
         compare_run("rand", cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
